// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - active-low segment patterns {A..G} and reader FSM encoding
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] ST_SETTLE = 2'd0;
  localparam logic [1:0] ST_OUT    = 2'd1;
  localparam logic [1:0] ST_LOCK   = 2'd2;

endpackage

// File: rtl/seven_seg_reader_if.sv
// rtl/seven_seg_reader_if.sv - segment lines in, decoded symbol handshake out
interface seven_seg_reader_if;

  logic A, B, C, D, E, F, G;
  logic x3, x2, x1, x0;
  logic valid;
  logic err;
  logic blank;
  logic ready;

  modport master (
    output A, B, C, D, E, F, G, ready,
    input  x3, x2, x1, x0, valid, err, blank
  );

  modport slave (
    input  A, B, C, D, E, F, G, ready,
    output x3, x2, x1, x0, valid, err, blank
  );

endinterface

// File: rtl/seg_pattern_classify.sv
// rtl/seg_pattern_classify.sv - maps an active-low segment pattern to its hex nibble
module seg_pattern_classify
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       hit,
  output logic       is_blank
);

  always_comb begin
    nibble   = 4'd0;
    hit      = 1'b1;
    is_blank = 1'b0;
    case (pattern)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
      SEG_BLANK: begin
        hit      = 1'b0;
        is_blank = 1'b1;
      end
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_reader.sv
// rtl/seven_seg_reader.sv - debounced 7-segment readback, one transaction per displayed symbol
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input logic               clk,
  input logic               reset,
  seven_seg_reader_if.slave bus
);

  localparam logic [CNT_W-1:0] STABLE_M1  = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYC);

  logic [6:0]       seg_d, seg_q, seg_p_d, seg_p_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [1:0]       state_d, state_q;
  logic [6:0]       lock_pat_d, lock_pat_q;
  logic [3:0]       x_d, x_q;
  logic             valid_d, valid_q;
  logic             err_d, err_q;
  logic             blank_d, blank_q;

  logic [3:0]       cls_nibble;
  logic             cls_hit;
  logic             cls_blank;
  logic             seg_stable;

  seg_pattern_classify u_classify (
    .pattern  (seg_q),
    .nibble   (cls_nibble),
    .hit      (cls_hit),
    .is_blank (cls_blank)
  );

  assign seg_stable = (seg_q == seg_p_q);

  always_comb begin
    seg_d      = {bus.A, bus.B, bus.C, bus.D, bus.E, bus.F, bus.G};
    seg_p_d    = seg_q;
    state_d    = state_q;
    lock_pat_d = lock_pat_q;
    x_d        = x_q;
    valid_d    = valid_q;
    err_d      = err_q;
    blank_d    = blank_q;

    if (!seg_stable)
      cnt_d = '0;
    else if (cnt_q != STABLE_MAX)
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;

    case (state_q)
      ST_SETTLE: begin
        if (seg_stable && (cnt_q == STABLE_M1)) begin
          lock_pat_d = seg_q;
          if (cls_blank) begin
            state_d = ST_LOCK;
            blank_d = 1'b1;
          end else begin
            state_d = ST_OUT;
            valid_d = 1'b1;
            x_d     = cls_hit ? cls_nibble : 4'd0;
            err_d   = !cls_hit;
          end
        end
      end
      ST_OUT: begin
        // x/err stay frozen here; the input keeps being sampled but is not acted on
        if (bus.ready) begin
          state_d = ST_LOCK;
          valid_d = 1'b0;
        end
      end
      ST_LOCK: begin
        if (seg_q != lock_pat_q) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
          blank_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_SETTLE;
        valid_d = 1'b0;
        blank_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    seg_q   <= seg_d;
    seg_p_q <= seg_p_d;
    if (reset) begin
      cnt_q      <= '0;
      state_q    <= ST_SETTLE;
      lock_pat_q <= SEG_BLANK;
      x_q        <= 4'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      blank_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      lock_pat_q <= lock_pat_d;
      x_q        <= x_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      blank_q    <= blank_d;
    end
  end

  assign bus.x3    = x_q[3];
  assign bus.x2    = x_q[2];
  assign bus.x1    = x_q[1];
  assign bus.x0    = x_q[0];
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.blank = blank_q;

endmodule
